// File: rtl/msm_rd_burst_issuer_if.sv
// rtl/msm_rd_burst_issuer_if.sv - AXI4 AR channel plus observed R handshake signals
interface msm_rd_burst_issuer_if #(
    parameter int C_ADDR_WIDTH = 64
);
    logic                    arvalid;
    logic                    arready;
    logic [C_ADDR_WIDTH-1:0] araddr;
    logic [7:0]              arlen;
    logic                    rvalid;
    logic                    rready;
    logic                    rlast;

    modport master (
        output arvalid, araddr, arlen,
        input  arready, rvalid, rready, rlast
    );

    modport slave (
        input  arvalid, araddr, arlen,
        output arready, rvalid, rready, rlast
    );
endinterface

// File: rtl/msm_rd_burst_issuer.sv
// rtl/msm_rd_burst_issuer.sv - splits a read transfer into AXI4 AR bursts with an outstanding-burst throttle
module msm_rd_burst_issuer #(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_DATA_WIDTH      = 512,
    parameter int C_XFER_SIZE_WIDTH = 32,
    parameter int C_BURST_LEN       = 64,
    parameter int C_MAX_OUTSTANDING = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 ctrl_start,
    input  logic [C_ADDR_WIDTH-1:0]              ctrl_addr_offset,
    input  logic [C_XFER_SIZE_WIDTH-1:0]         ctrl_xfer_beats,
    output logic                                 ctrl_done,
    output logic                                 busy,
    output logic                                 err,
    output logic [$clog2(C_MAX_OUTSTANDING):0]   outstanding,
    msm_rd_burst_issuer_if.master                m_axi
);
    localparam int BURST_BYTES = C_BURST_LEN * (C_DATA_WIDTH / 8);
    localparam int ADDR_LSB    = $clog2(BURST_BYTES);
    localparam int LEN_LSB     = $clog2(C_BURST_LEN);
    localparam int CNT_W       = C_XFER_SIZE_WIDTH - LEN_LSB + 1;
    localparam int OUT_W       = $clog2(C_MAX_OUTSTANDING) + 1;

    localparam logic [C_ADDR_WIDTH-1:0] BASE_MASK = {C_ADDR_WIDTH{1'b1}} << ADDR_LSB;
    localparam logic [C_ADDR_WIDTH-1:0] ADDR_STEP = C_ADDR_WIDTH'(BURST_BYTES);
    localparam logic [7:0]              FULL_LEN  = 8'(C_BURST_LEN - 1);
    localparam logic [OUT_W-1:0]        MAX_OUT   = OUT_W'(C_MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [C_ADDR_WIDTH-1:0] next_addr;
    logic [CNT_W-1:0]        bursts_left;
    logic [LEN_LSB-1:0]      rem_q;

    logic                    ar_hs, r_last_hs, start_ok, load;
    logic [OUT_W-1:0]        out_nxt;
    logic [LEN_LSB-1:0]      start_rem;
    logic [CNT_W-1:0]        start_total;
    logic [C_ADDR_WIDTH-1:0] src_addr;
    logic [CNT_W-1:0]        src_left;
    logic [LEN_LSB-1:0]      src_rem;
    logic [7:0]              src_len;

    assign busy = (state != IDLE) | ctrl_done;

    always_comb begin
        ar_hs       = m_axi.arvalid & m_axi.arready;
        r_last_hs   = m_axi.rvalid & m_axi.rready & m_axi.rlast;
        start_ok    = ctrl_start & ~busy;
        start_rem   = ctrl_xfer_beats[LEN_LSB-1:0];
        start_total = CNT_W'(ctrl_xfer_beats >> LEN_LSB) + CNT_W'(start_rem != '0);

        out_nxt = outstanding;
        if (ar_hs && !r_last_hs) begin
            out_nxt = outstanding + OUT_W'(1);
        end else if (!ar_hs && r_last_hs && outstanding != '0) begin
            out_nxt = outstanding - OUT_W'(1);
        end

        // The first burst is loaded straight from the start inputs so arvalid appears one cycle after start.
        src_addr = start_ok ? (ctrl_addr_offset & BASE_MASK) : next_addr;
        src_left = start_ok ? start_total : bursts_left;
        src_rem  = start_ok ? start_rem : rem_q;
        src_len  = (src_left == CNT_W'(1) && src_rem != '0) ? 8'(src_rem) - 8'd1 : FULL_LEN;

        // Throttle on the count as it will stand after this edge, so a pending burst is never overcommitted.
        load = (out_nxt < MAX_OUT) &&
               ((start_ok && start_total != '0) ||
                (state == ISSUE && (!m_axi.arvalid || ar_hs) && bursts_left != '0));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = (ctrl_xfer_beats != '0) ? ISSUE : DONE;
            ISSUE:   if (ar_hs && bursts_left == '0) state_nxt = DRAIN;
            DRAIN:   if (out_nxt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axi.arvalid <= 1'b0;
            m_axi.araddr  <= '0;
            m_axi.arlen   <= '0;
            next_addr     <= '0;
            bursts_left   <= '0;
            rem_q         <= '0;
            outstanding   <= '0;
            err           <= 1'b0;
            ctrl_done     <= 1'b0;
        end else begin
            outstanding <= out_nxt;
            ctrl_done   <= (state == DONE);
            if (start_ok) begin
                err <= 1'b0;
            end else if (r_last_hs && !ar_hs && outstanding == '0) begin
                err <= 1'b1;
            end
            if (load) begin
                m_axi.arvalid <= 1'b1;
                m_axi.araddr  <= src_addr;
                m_axi.arlen   <= src_len;
                next_addr     <= src_addr + ADDR_STEP;
                bursts_left   <= src_left - CNT_W'(1);
                rem_q         <= src_rem;
            end else if (ar_hs) begin
                m_axi.arvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_msm_rd_burst_issuer.sv
// tb/tb_msm_rd_burst_issuer.sv - randomized bench for msm_rd_burst_issuer against a transfer-level model
module tb_msm_rd_burst_issuer;
    localparam int MAXO = 16;
    localparam int BL   = 64;
    localparam longint BB = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ctrl_start;
    logic [63:0] ctrl_addr_offset;
    logic [31:0] ctrl_xfer_beats;
    logic        ctrl_done, busy, err;
    logic [4:0]  outstanding;

    always #5 clk = ~clk;

    msm_rd_burst_issuer_if #(.C_ADDR_WIDTH(64)) axi_if ();

    msm_rd_burst_issuer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ctrl_start       (ctrl_start),
        .ctrl_addr_offset (ctrl_addr_offset),
        .ctrl_xfer_beats  (ctrl_xfer_beats),
        .ctrl_done        (ctrl_done),
        .busy             (busy),
        .err              (err),
        .outstanding      (outstanding),
        .m_axi            (axi_if)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [63:0] m_base;
    longint      m_full, m_total, m_issued;
    int          m_rem, m_out, start_c, done_due;
    bit          m_err, m_active, done_seen;
    int          ar_mode, r_mode;
    bit          prev_hold;
    logic [63:0] prev_addr;
    logic [7:0]  prev_len;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_total = 0; m_issued = 0; m_full = 0; m_rem = 0; m_out = 0;
        m_err = 0; m_active = 0; start_c = 0; done_due = -1;
        done_seen = 0; prev_hold = 0;
    endtask

    // One clock: check outputs at the falling edge, drive inputs, update the model with this cycle's events.
    task automatic tick(input bit st, input logic [63:0] a, input logic [31:0] b);
        bit exp_busy, ar_hs, rl;
        exp_busy = m_active && (cyc > start_c);
        chk("outstanding", outstanding, m_out);
        chk("ctrl_done", ctrl_done, cyc == done_due);
        chk("busy", busy, exp_busy);
        chk("err", err, m_err);
        chk("arvalid_spurious", axi_if.arvalid && (m_issued >= m_total), 0);
        if (prev_hold) begin
            chk("hold_valid", axi_if.arvalid, 1);
            chk("hold_addr", axi_if.araddr, prev_addr);
            chk("hold_len", axi_if.arlen, prev_len);
        end else if (axi_if.arvalid) begin
            chk("throttle", m_out < MAXO, 1);
        end
        if (m_active && m_total > 0 && cyc == start_c + 1) chk("first_ar_latency", axi_if.arvalid, 1);
        if (cyc == done_due) begin
            m_active  = 0;
            done_seen = 1;
        end

        ctrl_start       = st;
        ctrl_addr_offset = a;
        ctrl_xfer_beats  = b;
        case (ar_mode)
            0:       axi_if.arready = 1'($urandom_range(0, 1));
            1:       axi_if.arready = 1'b1;
            default: axi_if.arready = 1'b0;
        endcase
        case (r_mode)
            1: begin
                axi_if.rvalid = 1'($urandom_range(0, 1));
                axi_if.rready = ($urandom_range(0, 3) != 0);
                axi_if.rlast  = (m_out > 0) && ($urandom_range(0, 1) == 1);
            end
            2: begin
                axi_if.rvalid = (m_out > 0);
                axi_if.rready = (m_out > 0);
                axi_if.rlast  = (m_out > 0);
            end
            4: begin
                axi_if.rvalid = 1'b1; axi_if.rready = 1'b1; axi_if.rlast = 1'b1;
            end
            default: begin
                axi_if.rvalid = 1'b0; axi_if.rready = 1'b0; axi_if.rlast = 1'b0;
            end
        endcase

        ar_hs = axi_if.arvalid && axi_if.arready;
        rl    = axi_if.rvalid && axi_if.rready && axi_if.rlast;
        prev_hold = axi_if.arvalid && !axi_if.arready;
        prev_addr = axi_if.araddr;
        prev_len  = axi_if.arlen;

        if (ar_hs) begin
            if (m_issued < m_total) begin
                chk("araddr", axi_if.araddr, m_base + 64'(m_issued) * 64'(BB));
                chk("arlen", axi_if.arlen, (m_issued < m_full) ? 64'(BL - 1) : 64'(m_rem - 1));
            end else begin
                chk("unexpected_ar", 1, 0);
            end
            m_issued++;
        end
        if (ar_hs && !rl) m_out++;
        else if (rl && !ar_hs) begin
            if (m_out == 0) m_err = 1;
            else m_out--;
        end
        if (rl && m_active && done_due < 0 && m_out == 0 && m_total > 0 && m_issued == m_total)
            done_due = cyc + 2;
        if (st && !exp_busy) begin
            m_err     = 0;
            m_active  = 1;
            done_seen = 0;
            start_c   = cyc;
            m_base    = a & ~64'hFFF;
            m_full    = longint'(b) / BL;
            m_rem     = int'(longint'(b) % BL);
            m_total   = m_full + ((m_rem != 0) ? 1 : 0);
            m_issued  = 0;
            done_due  = (b == 0) ? cyc + 2 : -1;
        end

        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic finish_xfer(input int am, input int rm, input bit strays);
        int n;
        ar_mode = am;
        r_mode  = rm;
        n = 0;
        while (!done_seen && n < 6000) begin
            if (strays && $urandom_range(0, 7) == 0) tick(1, {$urandom, $urandom}, $urandom);
            else tick(0, 64'h0, 32'h0);
            n++;
        end
        chk("xfer_timeout", done_seen, 1);
    endtask

    task automatic run_xfer(input logic [63:0] a, input logic [31:0] b, input int am, input int rm, input bit strays);
        ar_mode = am;
        r_mode  = rm;
        tick(1, a, b);
        finish_xfer(am, rm, strays);
    endtask

    initial begin
        rst_n = 1'b0;
        ctrl_start = 1'b0; ctrl_addr_offset = '0; ctrl_xfer_beats = '0;
        axi_if.arready = 1'b0; axi_if.rvalid = 1'b0; axi_if.rready = 1'b0; axi_if.rlast = 1'b0;
        ar_mode = 1; r_mode = 0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_arvalid", axi_if.arvalid, 0);
        chk("rst_araddr", axi_if.araddr, 0);
        chk("rst_arlen", axi_if.arlen, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_done", ctrl_done, 0);
        chk("rst_outstanding", outstanding, 0);

        run_xfer(64'h1000, 256, 1, 2, 0);
        chk("t1_bursts", m_issued, 4);
        chk("t1_out_end", outstanding, 0);

        run_xfer(64'h0, 130, 1, 2, 0);
        chk("t2_bursts", m_issued, 3);

        ar_mode = 1; r_mode = 0;
        tick(1, 64'h20000, 32'd2560);
        repeat (40) tick(0, 64'h0, 32'h0);
        chk("t3_sat_out", outstanding, 16);
        chk("t3_sat_issued", m_issued, 16);
        chk("t3_sat_arvalid", axi_if.arvalid, 0);
        r_mode = 2;
        tick(0, 64'h0, 32'h0);
        r_mode = 0;
        repeat (5) tick(0, 64'h0, 32'h0);
        chk("t3_refill", m_issued, 17);
        finish_xfer(1, 2, 0);

        ar_mode = 2; r_mode = 0;
        tick(1, 64'h7_0000_0123, 32'd300);
        repeat (12) tick(0, 64'h0, 32'h0);
        chk("t4_held_valid", axi_if.arvalid, 1);
        chk("t4_held_addr", axi_if.araddr, 64'h7_0000_0000);
        chk("t4_held_len", axi_if.arlen, 63);
        finish_xfer(0, 1, 1);

        run_xfer(64'hABC000, 0, 1, 0, 1);
        ar_mode = 0; r_mode = 4;
        tick(0, 64'h0, 32'h0);
        r_mode = 0;
        tick(0, 64'h0, 32'h0);
        chk("t5_err_set", err, 1);
        chk("t5_out_zero", outstanding, 0);
        run_xfer(64'h5000, 70, 0, 1, 0);
        chk("t5_err_cleared", err, 0);

        for (int i = 0; i < 10; i++)
            run_xfer({$urandom, $urandom}, 32'($urandom_range(1, 1500)), 0, 1, 1);

        ar_mode = 1; r_mode = 2;
        tick(1, 64'hFFFF_FFFF_FFFF_8000, 32'hFFFF_FFFF);
        repeat (30) tick(0, 64'h0, 32'h0);
        ar_mode = 2;
        repeat (3) tick(0, 64'h0, 32'h0);
        chk("t6_pre_arvalid", axi_if.arvalid, 1);
        chk("t6_pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_arvalid", axi_if.arvalid, 0);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_out", outstanding, 0);
        axi_if.arready = 1'b0; axi_if.rvalid = 1'b0; axi_if.rready = 1'b0; axi_if.rlast = 1'b0;
        ctrl_start = 1'b0;
        model_clear();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
        run_xfer(64'h3000, 128, 1, 2, 0);
        chk("t6_bursts", m_issued, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/msm_rd_burst_issuer.md
Name: msm_rd_burst_issuer

Overview:
- AXI4 read-address issue stage for the MSM kernel's point/scalar fetch path.
- Splits one transfer request (base address, length in beats) into AR bursts and tracks outstanding bursts with an up/down counter: +1 per AR handshake, -1 per R-last handshake.
- Throttles issue at a fixed outstanding limit.
- Signals done once every burst has been issued and every burst has returned.
- Sits between the kernel control FSM and the AXI read master port. The R data path is observed here, not consumed.

Parameters:
- C_ADDR_WIDTH, 64, AXI address width.
- C_DATA_WIDTH, 512, AXI data width in bits; bytes per beat = C_DATA_WIDTH/8.
- C_XFER_SIZE_WIDTH, 32, width of the transfer length in beats.
- C_BURST_LEN, 64, maximum beats per burst, power of 2, ≤256. Burst bytes must be ≤4096.
- C_MAX_OUTSTANDING, 16, maximum bursts in flight, power of 2, ≥2.

Ports:
- clk  in  1  Kernel clock; all logic on its rising edge.
- rst_n  in  1  Asynchronous active-low reset.
- ctrl_start  in  1  Single-cycle start pulse. Ignored while busy=1.
- ctrl_addr_offset  in  C_ADDR_WIDTH  Base byte address, sampled on an accepted start.
- ctrl_xfer_beats  in  C_XFER_SIZE_WIDTH  Total beats, sampled on an accepted start.
- ctrl_done  out  1  One-cycle completion pulse.
- busy  out  1  High from the cycle after an accepted start through the ctrl_done cycle.
- err  out  1  Sticky protocol error; cleared on an accepted start.
- outstanding  out  $clog2(C_MAX_OUTSTANDING)+1  Current count of bursts in flight.
- m_axi_arvalid  out  1  AR valid.
- m_axi_arready  in  1  AR ready.
- m_axi_araddr  out  C_ADDR_WIDTH  AR address.
- m_axi_arlen  out  8  AR length; value is beats-1.
- m_axi_rvalid  in  1  R valid (observed only).
- m_axi_rready  in  1  R ready as driven by the downstream consumer (observed only).
- m_axi_rlast  in  1  R last (observed only).

Behaviour:
Reset (asynchronous, takes effect immediately, including mid-operation):
- State IDLE; m_axi_arvalid=0, araddr=0, arlen=0.
- ctrl_done=0, busy=0, err=0, outstanding=0.
- Bursts already in flight when reset is applied are forgotten. The system must reset the AXI interconnect together with this block.

Address rules:
- The low log2(C_BURST_LEN*C_DATA_WIDTH/8) bits of ctrl_addr_offset are forced to 0.
- Each burst advances the address by C_BURST_LEN*bytes-per-beat, so no burst crosses a 4 KB boundary.

Burst split:
- N_full = beats/C_BURST_LEN bursts with arlen=C_BURST_LEN-1.
- Then one remainder burst with arlen=(beats mod C_BURST_LEN)-1, only if the remainder is non-zero.
- The remainder burst is always issued last.

Events:
- ar_hs = arvalid & arready.
- r_last_hs = rvalid & rready & rlast.

Outstanding counter:
- ar_hs only: +1. r_last_hs only: -1. Both in the same cycle, or neither: unchanged.
- r_last_hs while outstanding=0: the counter stays at 0 (no wrap) and err is set to 1.

States:
- IDLE
  - An accepted start with beats>0 goes to ISSUE.
  - An accepted start with beats=0 goes to DONE. No AR is issued.
- ISSUE
  - arvalid rises only when outstanding<C_MAX_OUTSTANDING (registered value).
  - Once arvalid=1, araddr, arlen and arvalid are held stable until ar_hs (AXI rule). The throttle never drops a pending arvalid.
  - The registered count can therefore never exceed C_MAX_OUTSTANDING.
  - On the ar_hs of the last burst, go to DRAIN.
- DRAIN
  - When outstanding reaches 0, go to DONE.
  - Also go to DONE when outstanding=1 and r_last_hs occurs; the transition is taken in that same cycle.
- DONE
  - ctrl_done=1 for exactly one cycle, then IDLE. busy falls with the return to IDLE.

Latency:
- Accepted start at cycle N gives the first m_axi_arvalid=1 at N+1, if the throttle allows.
- Back-to-back ar_hs is sustainable: one burst per cycle while arready=1 and below the limit.
- ctrl_done is asserted 2 cycles after the final r_last_hs.
- beats=0: ctrl_done is asserted at N+2.

Simultaneous events:
- ctrl_start while busy is ignored; its inputs are not sampled.
- ctrl_start in the same cycle as ctrl_done is ignored.

Length extremes:
- beats = 2^C_XFER_SIZE_WIDTH-1 must split correctly.
- The burst counter width is C_XFER_SIZE_WIDTH-log2(C_BURST_LEN)+1.

Test Plan:
1. beats=256, addr=0x1000, arready=1, R returns immediately -> 4 bursts: araddr 0x1000, 0x2000, 0x3000, 0x4000; each arlen=63; ctrl_done exactly once; outstanding ends at 0.
2. beats=130, addr=0x0 -> bursts arlen 63, 63, 1 at 0x0, 0x1000, 0x2000; the remainder burst is last.
3. beats=64*40, arready=1, no R returns -> exactly 16 ar_hs, then arvalid stays 0 and outstanding=16. Release one rlast -> one more burst is issued in the following cycles. Drain all -> ctrl_done.
4. arready held 0 for 10 cycles after arvalid rises -> araddr and arlen stable and arvalid held. Same-cycle ar_hs and r_last_hs -> outstanding unchanged.
5. beats=0 -> no arvalid; ctrl_done at start+2. Then an rlast pulse while idle -> err=1, outstanding stays 0. Next start clears err.
6. rst_n low mid-ISSUE with arvalid=1 -> arvalid, busy and outstanding go to 0 without waiting for a clock edge. A new start after release begins at the new base.
